uart_rx_ext: RTL



---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_sync.sv | 32 +++
 rtl/uart_rx_ext.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared state encoding and bit-timing helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_rx_state_t;

    // The middle vote sample sits this many clocks before the half-bit point.
    localparam int SAMPLE_OFFSET = 1;

    function automatic int calc_baud_cnt_max(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Three-flop synchroniser for the serial line plus a falling-edge detector on
// the synchronised output. All flops reset to the idle level 1.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic rxd_s,
    output logic fall
);

    logic [2:0] sync_q, sync_d;
    logic       prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[1:0], rxd};
        prev_d = sync_q[2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 3'b111;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rxd_s = sync_q[2];
    assign fall  = prev_q & ~sync_q[2];

endmodule

// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver: majority-voted sampling, false-start rejection,
// valid/ready output register. Parity is compiled in with UART_RX_PARITY_EN.
module uart_rx_ext
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int UART_BPS   = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rxd,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic [2:0]           state_dbg
);

    localparam int BAUD_CNT_MAX = calc_baud_cnt_max(CLK_FREQ, UART_BPS);
    localparam int SAMPLE       = BAUD_CNT_MAX / 2 - SAMPLE_OFFSET;

    localparam logic [15:0] CNT_LAST  = 16'(BAUD_CNT_MAX - 1);
    localparam logic [15:0] SMP_PRE   = 16'(SAMPLE - 1);
    localparam logic [15:0] SMP_MID   = 16'(SAMPLE);
    localparam logic [15:0] SMP_DEC   = 16'(SAMPLE + 1);
    localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);

    if (BAUD_CNT_MAX < 8) begin : g_chk_baud
        $error("uart_rx_ext: CLK_FREQ/UART_BPS must be at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
        $error("uart_rx_ext: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
        $error("uart_rx_ext: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_chk_par
        $error("uart_rx_ext: PARITY_ODD must be 0 or 1");
    end

    logic rxd_s;
    logic fall;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .rxd   (uart_rxd),
        .rxd_s (rxd_s),
        .fall  (fall)
    );

    uart_rx_state_t         state_q, state_d;
    logic [15:0]            baud_q, baud_d;
    logic [3:0]             bit_q, bit_d;
    logic [1:0]             smp_q, smp_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   ferr_flag_q, ferr_flag_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_err_q, overrun_err_d;
    logic                   maj, decide, wrap, done;
`ifdef UART_RX_PARITY_EN
    logic                   perr_flag_q, perr_flag_d;
    logic                   parity_err_q, parity_err_d;
`endif

    // The third vote is the live synchronised sample in the decision cycle.
    assign maj    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxd_s) | (smp_q[1] & rxd_s);
    assign decide = (baud_q == SMP_DEC);
    assign wrap   = (baud_q == CNT_LAST);

    always_comb begin
        state_d       = state_q;
        baud_d        = baud_q;
        bit_d         = bit_q;
        smp_d         = smp_q;
        shift_d       = shift_q;
        ferr_flag_d   = ferr_flag_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q & ~rx_ready;
        frame_err_d   = 1'b0;
        overrun_err_d = 1'b0;
        done          = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_flag_d   = perr_flag_q;
        parity_err_d  = 1'b0;
`endif

        if (state_q != IDLE) begin
            baud_d = wrap ? 16'd0 : baud_q + 16'd1;
            if (baud_q == SMP_PRE) smp_d[0] = rxd_s;
            if (baud_q == SMP_MID) smp_d[1] = rxd_s;
        end

        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d     = START;
                    baud_d      = 16'd0;
                    bit_d       = 4'd0;
                    ferr_flag_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                    perr_flag_d = 1'b0;
`endif
                end
            end
            START: begin
                if (decide && maj) begin
                    state_d = IDLE;
                    baud_d  = 16'd0;
                end else if (wrap) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (decide) shift_d = {maj, shift_q[DATA_BITS-1:1]};
                if (wrap) begin
                    bit_d = bit_q + 4'd1;
                    if (bit_q == DATA_LAST) begin
                        bit_d = 4'd0;
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (decide) perr_flag_d = maj ^ (^shift_q) ^ (PARITY_ODD != 0);
                if (wrap) state_d = STOP;
            end
`endif
            STOP: begin
                if (decide) begin
                    if (!maj) ferr_flag_d = 1'b1;
                    // Leave mid-bit so a new start edge is caught right away.
                    if (bit_q == STOP_LAST) begin
                        state_d = IDLE;
                        baud_d  = 16'd0;
                        done    = 1'b1;
                    end
                end
                if (wrap) bit_d = bit_q + 4'd1;
            end
            default: state_d = IDLE;
        endcase

        if (done) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d    = shift_q;
                rx_valid_d   = 1'b1;
                frame_err_d  = ferr_flag_d;
`ifdef UART_RX_PARITY_EN
                parity_err_d = perr_flag_q;
`endif
            end else begin
                overrun_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            baud_q        <= 16'd0;
            bit_q         <= 4'd0;
            smp_q         <= 2'b11;
            shift_q       <= '0;
            ferr_flag_q   <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            baud_q        <= baud_d;
            bit_q         <= bit_d;
            smp_q         <= smp_d;
            shift_q       <= shift_d;
            ferr_flag_q   <= ferr_flag_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perr_flag_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            perr_flag_q  <= perr_flag_d;
            parity_err_q <= parity_err_d;
        end
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_busy     = (state_q != IDLE);
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;
    assign state_dbg   = state_q;

endmodule
